// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the iterative logarithmic shifter sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int SHAMT_W   = $clog2(WIDTH_DEF);

    // Widest datapath bit_reverse can serve; callers zero-extend into this
    // width and use the low w bits of the result.
    localparam int REV_MAX_W = 128;
    localparam int REV_IDX_W = $clog2(REV_MAX_W);

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [REV_MAX_W-1:0] bit_reverse(
        input logic [REV_MAX_W-1:0] v,
        input int unsigned          w
    );
        logic [REV_MAX_W-1:0] r;
        logic [REV_IDX_W-1:0] idx;
        r = '0;
        for (int i = 0; i < REV_MAX_W; i++) begin
            if (i < int'(w)) begin
                idx  = REV_IDX_W'(int'(w) - 1 - i);
                r[i] = v[idx];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_var_stage.sv
// Single shared shift stage: right shift by 2^k with an external fill bit.

// Basic 1-bit 2:1 mux cell used to build the stage.
module mux2x1_1b (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // sel=0 passes a, sel=1 passes b.
    assign y = sel ? b : a;

endmodule

// The stage is a cascade of SHAMT_W mux rows, one per power of two. Exactly
// one row is enabled by the decoded k, so the cascade performs a single shift
// of 2^k; an out-of-range k leaves every row transparent.
module shift_var_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int KW      = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic [KW-1:0]    k,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    logic [SHAMT_W-1:0]            sel;
    logic [SHAMT_W:0][WIDTH-1:0]   lvl;

    // One-hot row enable from the stage index.
    always_comb begin
        sel = '0;
        for (int j = 0; j < SHAMT_W; j++) begin
            sel[j] = (k == KW'(j));
        end
    end

    assign lvl[0] = din;

    for (genvar j = 0; j < SHAMT_W; j++) begin : g_row
        localparam int DIST = 1 << j;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic shifted;
            if (i + DIST < WIDTH) begin : g_src
                assign shifted = lvl[j][i+DIST];
            end else begin : g_fill
                assign shifted = fill;
            end
            mux2x1_1b u_mux (
                .a   (lvl[j][i]),
                .b   (shifted),
                .sel (sel[j]),
                .y   (lvl[j+1][i])
            );
        end
    end

    assign dout = lvl[SHAMT_W];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: walks one shared right-shift stage through
// weights 2^(SHAMT_W-1) .. 1, so every request takes exactly SHAMT_W cycles.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a request; capture operand, shamt, op and fill
//   SHIFT   | one stage step per cycle, k counts down SHAMT_W-1 .. 0
//   DONE    | result presented, held until the consumer takes it
//
// Left shifts are done as right shifts on the bit-reversed operand; the
// reserved op is sequenced like SRL with a zero shift amount so the operand
// passes through unchanged and the error flag is raised.
module shift_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_operand,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_err,
    output logic               busy
);

    import shift_pkg::*;

    localparam int KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [KW-1:0] K_START = KW'(SHAMT_W - 1);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] shamt_q;
    shift_op_t          op_q;
    logic               fill_q;
    logic               err_q;

    logic               accept;
    logic               last_step;
    shift_op_t          in_op_e;
    logic [WIDTH-1:0]   stage_out;
    logic [WIDTH-1:0]   capture_val;

    logic [REV_MAX_W-1:0] rev_in_wide;
    logic [REV_MAX_W-1:0] rev_out_wide;
    logic                 unused_rev;

    assign in_op_e   = shift_op_t'(in_op);
    assign accept    = (state_q == S_IDLE) && in_valid;
    assign last_step = (k_q == '0);

    // Bit reversal for left shifts, applied at capture and again at output.
    assign rev_in_wide  = bit_reverse(REV_MAX_W'(in_operand), WIDTH);
    assign rev_out_wide = bit_reverse(REV_MAX_W'(work_q), WIDTH);
    assign unused_rev   = ^{rev_in_wide[REV_MAX_W-1:WIDTH], rev_out_wide[REV_MAX_W-1:WIDTH]};

    assign capture_val = (in_op_e == OP_SLL) ? rev_in_wide[WIDTH-1:0] : in_operand;

    shift_var_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .KW      (KW)
    ) u_stage (
        .din  (work_q),
        .k    (k_q),
        .fill (fill_q),
        .dout (stage_out)
    );

    // Next-state decode; DONE never accepts, even with out_ready high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_SHIFT;
            S_SHIFT: if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, per-step shifting and the step down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q     <= K_START;
            work_q  <= '0;
            shamt_q <= '0;
            op_q    <= OP_SRL;
            fill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            k_q     <= K_START;
            work_q  <= capture_val;
            op_q    <= in_op_e;
            // Reserved op shifts by nothing so the operand comes back as-is.
            shamt_q <= (in_op_e == OP_RSVD) ? '0 : in_shamt;
            // Fill is frozen here; the stage never looks at the live MSB.
            fill_q  <= (in_op_e == OP_SRA) ? in_operand[WIDTH-1] : 1'b0;
            err_q   <= (in_op_e == OP_RSVD);
        end else if (state_q == S_SHIFT) begin
            if (shamt_q[k_q]) begin
                work_q <= stage_out;
            end
            k_q <= last_step ? K_START : (k_q - KW'(1));
        end
    end

    // Handshake and result presentation.
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        busy       = (state_q == S_SHIFT) || (state_q == S_DONE);
        out_result = (op_q == OP_SLL) ? rev_out_wide[WIDTH-1:0] : work_q;
        out_err    = err_q;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a transaction-level model plus
// directed vectors with literal expected results.
module tb_shift_seq_ctrl;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [WIDTH-1:0]   in_operand;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;
    logic               out_err;
    logic               busy;

    int errors = 0;
    int checks = 0;

    // Model state: a request is either absent, in flight (counting down the
    // fixed latency) or waiting for the consumer.
    bit               m_busy  = 1'b0;
    bit               m_valid = 1'b0;
    int               m_cnt   = 0;
    logic [WIDTH-1:0] m_res   = '0;
    bit               m_err   = 1'b0;
    bit               chk_en  = 1'b0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] v,
                                                   input logic [SHAMT_W-1:0] s);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = v << s;
            2'b01:   r = v >> s;
            2'b10:   r = $signed(v) >>> s;
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        chk_en <= 1'b1;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) m_valid <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= SHAMT_W;
            m_res  <= ref_shift(in_op, in_operand, in_shamt);
            m_err  <= (in_op == 2'b11);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_result", out_result, m_res);
                chk("model_err", 32'(out_err), 32'(m_err));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] operand,
                          input logic [SHAMT_W-1:0] shamt, input logic [WIDTH-1:0] exp,
                          input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = operand;
        in_shamt   = shamt;
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs; the controller must ignore them once busy.
        in_valid   = 1'b0;
        in_op      = op ^ 2'b01;
        in_operand = ~operand;
        in_shamt   = ~shamt;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd6);
        chk("result", out_result, exp);
        chk("err", 32'(out_err), 32'(exp_err));
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) @(negedge clk);
            chk("hold_result", out_result, exp);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("released_valid", 32'(out_valid), 32'd0);
        chk("released_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 2'b00;
        in_operand = '0;
        in_shamt   = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        run_op(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 0);
        run_op(2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0, 0);
        run_op(2'b00, 32'h0000_0001, 5'd17, 32'h0002_0000, 1'b0, 0);
        run_op(2'b00, 32'hA5A5_0003, 5'd0,  32'hA5A5_0003, 1'b0, 0);
        run_op(2'b00, 32'h8000_0001, 5'd31, 32'h8000_0000, 1'b0, 0);
        run_op(2'b01, 32'h1234_0000, 5'd8,  32'h0012_3400, 1'b0, 10);
        run_op(2'b11, 32'h1234_5678, 5'd9,  32'h1234_5678, 1'b1, 0);
        run_op(2'b01, 32'hC000_0000, 5'd1,  32'h6000_0000, 1'b0, 0);

        // Reset during the third SHIFT cycle drops the request.
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = 2'b01;
        in_operand = 32'hDEAD_BEEF;
        in_shamt   = 5'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        run_op(2'b01, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit logarithmic shifter: accepts one shift request (SLL/SRL/SRA, 5-bit shamt) over a valid/ready handshake.
- Drives a single shared shift stage once per cycle through stage weights 16, 8, 4, 2, 1.
- Returns the result over a valid/ready handshake.
- Sits between the ALU op decoder and the ALU result mux as the area-reduced alternative to the fully unrolled five-stage shifter.

Parameters:
- WIDTH, 32, datapath width; must be a power of two ≥ 8.
- SHAMT_W, $clog2(WIDTH) (5), shift-amount width and number of stage iterations.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request.
- in_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved.
- in_operand  input  WIDTH  value to shift.
- in_shamt  input  SHAMT_W  shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_result  output  WIDTH  shifted value.
- out_err  output  1  request used reserved op; qualified by out_valid.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: clk and rst_n as above; rst_n is synchronous and active-low. When rst_n=0 at a rising edge:
  - state<=IDLE, step counter<=SHAMT_W-1, working register<=0, out_err<=0.
  - Outputs after reset: out_valid=0, out_result=0, out_err=0, busy=0, in_ready=1.
  - Reset mid-operation discards the request with no output.
- States:
  - IDLE: in_ready=1. Transfer on in_valid&&in_ready. Captures operand into the working register, plus shamt, op, and fill bit (operand[WIDTH-1] for SRA, else 0). k<=SHAMT_W-1. Next state SHIFT.
  - SHIFT: in_ready=0. Each cycle, if shamt[k]=1 the working register <= stage(working, 2^k, fill); otherwise it holds. k decrements. Exits to DONE after the k=0 step.
  - DONE: out_valid=1; out_result is the working register. Holds stable until out_ready=1, then next state IDLE.
- Fixed latency: acceptance at edge T0; out_valid high starting the cycle after edge T0+SHAMT_W (5 SHIFT cycles). Latency does not depend on shamt, including shamt=0.
- Minimum turnaround is SHAMT_W+2 cycles per op. No acceptance while in DONE, even if out_ready=1 in that cycle.
- Left shift: operand is bit-reversed on capture and the result bit-reversed on output; the stage always shifts right. SLL fill is always 0.
- Reserved op (11): treated as SRL for sequencing, result = operand unchanged, out_err=1. Same latency.
- Fill bit is latched at acceptance. Stage fills from the latched bit, never from the current working-register MSB.
- Input changes while not in IDLE are ignored. out_result and out_err are stable throughout DONE.
- No wrap-around beyond shamt=WIDTH-1. SRA of a negative value by 31 yields all ones.

Decomposition:
- Shared package shift_pkg:
  - enum shift_op_t {OP_SLL, OP_SRL, OP_SRA, OP_RSVD}
  - enum shift_state_t {ST_IDLE, ST_SHIFT, ST_DONE}
  - localparam SHAMT_W
  - function bit_reverse.
- One sub-module, shift_var_stage: combinational right shift of WIDTH bits by 2^k (k as input), with fill, built from the existing mux2x1_1b cells.

Test Plan:
- SRL 0x8000_0000 by 31 -> 0x0000_0001; out_valid on the cycle after edge T0+5; out_err=0.
- SRA 0x8000_00F0 by 4 -> 0xF800_000F. SRA 0xFFFF_FFFF by 31 -> 0xFFFF_FFFF.
- SLL 0x0000_0001 by 17 -> 0x0002_0000. SLL by 0 -> operand unchanged, same 6-cycle latency.
- Backpressure: out_ready held 0 for 10 cycles; out_result stays stable, in_ready=0, and a new in_valid is not accepted until the cycle after out_ready=1.
- Reserved op: in_op=11, operand 0x1234_5678 -> result 0x1234_5678, out_err=1.
- Reset: rst_n=0 on the 3rd SHIFT cycle -> next cycle state IDLE, out_valid=0, in_ready=1. A following SRL 0xF0 by 4 returns 0x0F.
